// File: rtl/usb_rx_byte_assembler_pkg.sv
// usb_rx_pkg: receive-FSM states, SYNC pattern and PID integrity check
package usb_rx_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_ABORT} rx_state_e;
  localparam logic [7:0] USB_SYNC_PATTERN = 8'h80;
  function automatic logic pid_check(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction
endpackage

// File: rtl/usb_rx_byte_assembler.sv
// usb_rx_byte_assembler: SYNC hunt, LSB-first byte assembly, PID check and packet framing
module usb_rx_byte_assembler
  import usb_rx_pkg::*;
#(
  parameter int MAX_BYTES = 1026
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_eop,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_pid,
  output logic       rx_pid_ok,
  output logic       rx_active,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_error
);
  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);
  rx_state_e   state_q;
  logic [7:0]  shreg_q, shreg_d, data_q;
  logic [2:0]  bit_cnt_q;
  logic [10:0] byte_cnt_q;
  logic        valid_q, pid_q, pid_ok_q, active_q, sop_q, eop_q, error_q;
  assign shreg_d = {in_bit, shreg_q[7:1]};
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RX_IDLE;
      shreg_q    <= '0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      valid_q    <= 1'b0;
      pid_q      <= 1'b0;
      pid_ok_q   <= 1'b0;
      active_q   <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      pid_q    <= 1'b0;
      pid_ok_q <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      error_q  <= 1'b0;
      // EOP outranks a coincident bit; a partial byte only counts as an error while still assembling
      if (in_eop && state_q != RX_IDLE) begin
        state_q  <= RX_IDLE;
        shreg_q  <= '0;
        active_q <= 1'b0;
        eop_q    <= 1'b1;
        error_q  <= (state_q == RX_DATA) && (bit_cnt_q != 3'd0);
      end else begin
        case (state_q)
          RX_IDLE: if (in_valid) begin
            shreg_q <= shreg_d;
            if (shreg_d == USB_SYNC_PATTERN) begin
              state_q    <= RX_DATA;
              sop_q      <= 1'b1;
              active_q   <= 1'b1;
              bit_cnt_q  <= '0;
              byte_cnt_q <= '0;
            end
          end
          RX_DATA: if (in_valid) begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == MAX_CNT) begin
                state_q <= RX_ABORT;
                error_q <= 1'b1;
              end else begin
                data_q     <= shreg_d;
                valid_q    <= 1'b1;
                pid_q      <= byte_cnt_q == 11'd0;
                pid_ok_q   <= (byte_cnt_q == 11'd0) && pid_check(shreg_d);
                byte_cnt_q <= byte_cnt_q + 11'd1;
              end
            end
          end
          RX_ABORT: ;
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_pid    = pid_q;
  assign rx_pid_ok = pid_ok_q;
  assign rx_active = active_q;
  assign rx_sop    = sop_q;
  assign rx_eop    = eop_q;
  assign rx_error  = error_q;
endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// tb_usb_rx_byte_assembler: directed scenarios against hand-computed expectations
module tb_usb_rx_byte_assembler;
  logic clk = 1'b0, nRST = 1'b0, in_bit = 1'b0, in_valid = 1'b0, in_eop = 1'b0;
  logic [7:0] rx_data, o_data;
  logic rx_valid, rx_pid, rx_pid_ok, rx_active, rx_sop, rx_eop, rx_error;
  logic o_valid, o_pid, o_pid_ok, o_active, o_sop, o_eop, o_error;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  usb_rx_byte_assembler u_dut (
    .clk(clk), .nRST(nRST), .in_bit(in_bit), .in_valid(in_valid), .in_eop(in_eop),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_pid_ok(rx_pid_ok),
    .rx_active(rx_active), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_error(rx_error)
  );

  usb_rx_byte_assembler #(.MAX_BYTES(3)) u_ovf (
    .clk(clk), .nRST(nRST), .in_bit(in_bit), .in_valid(in_valid), .in_eop(in_eop),
    .rx_data(o_data), .rx_valid(o_valid), .rx_pid(o_pid), .rx_pid_ok(o_pid_ok),
    .rx_active(o_active), .rx_sop(o_sop), .rx_eop(o_eop), .rx_error(o_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) tick();
    in_bit = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int maxgap);
    for (int i = 0; i < 8; i++) send_bit(v[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic send_eop();
    in_eop = 1'b1;
    tick();
    in_eop = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({rx_data, rx_valid, rx_pid, rx_pid_ok, rx_active, rx_sop, rx_eop, rx_error} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", {rx_data, rx_valid, rx_pid, rx_pid_ok, rx_active, rx_sop, rx_eop, rx_error});
    end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_clean();
    send_byte(8'h80, 0);
    vectors++;
    if ({rx_sop, rx_active} !== 2'b11) begin miscompares++; $display("FAIL clean_sop got sop/active=%b want 11", {rx_sop, rx_active}); end
    send_byte(8'hA5, 0);
    vectors++;
    if ({rx_valid, rx_pid, rx_pid_ok, rx_data} !== {3'b111, 8'hA5}) begin
      miscompares++; $display("FAIL clean_pid got v/p/ok=%b data=%h want 111 a5", {rx_valid, rx_pid, rx_pid_ok}, rx_data);
    end
    send_byte(8'h3C, 0);
    vectors++;
    if ({rx_valid, rx_pid, rx_data} !== {2'b10, 8'h3C}) begin
      miscompares++; $display("FAIL clean_data got v/p=%b data=%h want 10 3c", {rx_valid, rx_pid}, rx_data);
    end
    tick();
    vectors++;
    if ({rx_valid, rx_data} !== {1'b0, 8'h3C}) begin
      miscompares++; $display("FAIL clean_hold got v=%b data=%h want 0 3c", rx_valid, rx_data);
    end
    send_eop();
    vectors++;
    if ({rx_eop, rx_error, rx_active} !== 3'b100) begin
      miscompares++; $display("FAIL clean_eop got eop/err/active=%b want 100", {rx_eop, rx_error, rx_active});
    end
    tick();
    vectors++;
    if (rx_eop !== 1'b0) begin miscompares++; $display("FAIL clean_eop_width got %b want 0", rx_eop); end
  endtask

  task automatic test_bad_pid();
    send_byte(8'h80, 0);
    send_byte(8'h55, 0);
    vectors++;
    if ({rx_valid, rx_pid, rx_pid_ok, rx_data} !== {3'b110, 8'h55}) begin
      miscompares++; $display("FAIL badpid got v/p/ok=%b data=%h want 110 55", {rx_valid, rx_pid, rx_pid_ok}, rx_data);
    end
    send_byte(8'h12, 0);
    vectors++;
    if ({rx_valid, rx_pid, rx_data} !== {2'b10, 8'h12}) begin
      miscompares++; $display("FAIL badpid_cont got v/p=%b data=%h want 10 12", {rx_valid, rx_pid}, rx_data);
    end
    send_eop();
    vectors++;
    if ({rx_eop, rx_error} !== 2'b10) begin miscompares++; $display("FAIL badpid_eop got eop/err=%b want 10", {rx_eop, rx_error}); end
  endtask

  task automatic test_misalign();
    logic [4:0] part = 5'b01101;
    send_byte(8'h80, 0);
    send_byte(8'hD2, 0);
    vectors++;
    if ({rx_valid, rx_pid, rx_pid_ok, rx_data} !== {3'b111, 8'hD2}) begin
      miscompares++; $display("FAIL misalign_pid got v/p/ok=%b data=%h want 111 d2", {rx_valid, rx_pid, rx_pid_ok}, rx_data);
    end
    for (int i = 0; i < 5; i++) send_bit(part[i], 0);
    send_eop();
    vectors++;
    if ({rx_eop, rx_error, rx_active} !== 3'b110) begin
      miscompares++; $display("FAIL misalign_eop got eop/err/active=%b want 110", {rx_eop, rx_error, rx_active});
    end
  endtask

  task automatic test_zero_bytes();
    send_byte(8'h80, 0);
    send_eop();
    vectors++;
    if ({rx_eop, rx_error} !== 2'b10) begin miscompares++; $display("FAIL empty_eop got eop/err=%b want 10", {rx_eop, rx_error}); end
    send_eop();
    vectors++;
    if ({rx_eop, rx_error, rx_active} !== 3'b000) begin
      miscompares++; $display("FAIL idle_eop got eop/err/active=%b want 000", {rx_eop, rx_error, rx_active});
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
    send_byte(8'h80, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], 0);
      vectors++;
      if ({o_valid, o_error, o_data} !== {2'b10, bytes[i]}) begin
        miscompares++; $display("FAIL ovf_byte%0d got v/err=%b data=%h want 10 %h", i, {o_valid, o_error}, o_data, bytes[i]);
      end
    end
    send_byte(8'h44, 0);
    vectors++;
    if ({o_valid, o_error, o_active, o_data} !== {3'b011, 8'h33}) begin
      miscompares++; $display("FAIL ovf_error got v/err/active=%b data=%h want 011 33", {o_valid, o_error, o_active}, o_data);
    end
    send_byte(8'hFF, 0);
    vectors++;
    if ({o_valid, o_error, o_sop, o_active} !== 4'b0001) begin
      miscompares++; $display("FAIL ovf_abort got v/err/sop/active=%b want 0001", {o_valid, o_error, o_sop, o_active});
    end
    vectors++;
    if ({rx_valid, rx_data} !== {1'b1, 8'hFF}) begin
      miscompares++; $display("FAIL ovf_default_dut got v=%b data=%h want 1 ff", rx_valid, rx_data);
    end
    send_eop();
    vectors++;
    if ({o_eop, o_error, o_active} !== 3'b100) begin
      miscompares++; $display("FAIL ovf_eop got eop/err/active=%b want 100", {o_eop, o_error, o_active});
    end
  endtask

  task automatic test_spaced_noise();
    int sops = 0;
    for (int i = 0; i < 12; i++) begin
      send_bit(1'b0, int'($urandom_range(0, 4)));
      sops += int'(rx_sop);
    end
    send_eop();
    sops += int'(rx_sop) + int'(rx_eop);
    vectors++;
    if (sops != 0) begin miscompares++; $display("FAIL noise_nosop got %0d sop/eop pulses want 0", sops); end
    send_byte(8'h80, 4);
    vectors++;
    if ({rx_sop, rx_active} !== 2'b11) begin miscompares++; $display("FAIL spaced_sop got sop/active=%b want 11", {rx_sop, rx_active}); end
    send_byte(8'hC3, 4);
    vectors++;
    if ({rx_valid, rx_pid, rx_pid_ok, rx_data} !== {3'b111, 8'hC3}) begin
      miscompares++; $display("FAIL spaced_pid got v/p/ok=%b data=%h want 111 c3", {rx_valid, rx_pid, rx_pid_ok}, rx_data);
    end
    send_byte(8'h5A, 4);
    vectors++;
    if ({rx_valid, rx_pid, rx_data} !== {2'b10, 8'h5A}) begin
      miscompares++; $display("FAIL spaced_data got v/p=%b data=%h want 10 5a", {rx_valid, rx_pid}, rx_data);
    end
    send_eop();
    vectors++;
    if ({rx_eop, rx_error} !== 2'b10) begin miscompares++; $display("FAIL spaced_eop got eop/err=%b want 10", {rx_eop, rx_error}); end
  endtask

  task automatic test_collision_reset();
    send_byte(8'h80, 0);
    send_byte(8'hA5, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    in_bit = 1'b1;
    in_valid = 1'b1;
    in_eop = 1'b1;
    tick();
    in_valid = 1'b0;
    in_eop = 1'b0;
    vectors++;
    if ({rx_eop, rx_error, rx_valid, rx_active} !== 4'b1100) begin
      miscompares++; $display("FAIL collision got eop/err/v/active=%b want 1100", {rx_eop, rx_error, rx_valid, rx_active});
    end
    send_byte(8'h80, 0);
    send_byte(8'h3C, 0);
    vectors++;
    if ({rx_valid, rx_pid, rx_data} !== {2'b11, 8'h3C}) begin
      miscompares++; $display("FAIL collision_next got v/p=%b data=%h want 11 3c", {rx_valid, rx_pid}, rx_data);
    end
    #2 nRST = 1'b0;
    #1;
    vectors++;
    if ({rx_data, rx_valid, rx_pid, rx_pid_ok, rx_active, rx_sop, rx_eop, rx_error} !== 15'd0) begin
      miscompares++;
      $display("FAIL async_reset got %h want 0", {rx_data, rx_valid, rx_pid, rx_pid_ok, rx_active, rx_sop, rx_eop, rx_error});
    end
    tick();
    vectors++;
    if ({rx_eop, rx_active} !== 2'b00) begin miscompares++; $display("FAIL reset_no_eop got eop/active=%b want 00", {rx_eop, rx_active}); end
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bad_pid();
    test_misalign();
    test_zero_bytes();
    test_overflow();
    test_spaced_noise();
    test_collision_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/usb_rx_byte_assembler.md
# usb_rx_byte_assembler

Receive-path stage directly downstream of the bit unstuffer. It consumes the unstuffed serial bit stream and hunts for the SYNC field. It then assembles LSB-first bytes, validates the PID byte and frames each packet with start/end pulses for the packet decoder. It also reports byte-alignment and over-length errors.

## Interface
- `MAX_BYTES`, default 1026 — maximum bytes per packet after SYNC, including the PID and CRC bytes; byte 1027 and beyond is an overflow.
- `clk` in 1 — system clock; all logic is on the rising edge.
- `nRST` in 1 — asynchronous, active-low reset.
- `in_bit` in 1 — unstuffed data bit.
- `in_valid` in 1 — `in_bit` is valid this cycle; single-cycle strobes, arbitrary spacing.
- `in_eop` in 1 — single-cycle pulse from the line-state detector marking SE0 end-of-packet.
- `rx_data` out 8 — assembled byte, LSB = first received bit.
- `rx_valid` out 1 — one-cycle strobe; `rx_data` is valid.
- `rx_pid` out 1 — qualifies `rx_valid`; this byte is the PID (first byte after SYNC).
- `rx_pid_ok` out 1 — sampled with `rx_pid`; true when `rx_data[7:4] == ~rx_data[3:0]`.
- `rx_active` out 1 — high from SYNC detection until the EOP is processed.
- `rx_sop` out 1 — one-cycle pulse when SYNC is detected.
- `rx_eop` out 1 — one-cycle pulse when a packet ends.
- `rx_error` out 1 — one-cycle pulse on an alignment error or an overflow.

## Operation
- **Reset:** all outputs are 0. State is IDLE. The shift register, bit counter and byte counter are 0.
- **Shift register:** on every accepted `in_valid`, `shreg <= {in_bit, shreg[7:1]}`.
- **IDLE (SYNC hunt):**
  - Shift on every `in_valid`.
  - When the post-shift value equals `8'h80` (seven 0s then a 1, as decoded from KJKJKJKK): go to DATA, pulse `rx_sop`, set `rx_active`, clear the bit and byte counters.
  - Ignore `in_eop` in IDLE.
- **DATA:**
  - Each `in_valid` shifts the register and increments the 3-bit bit counter, which wraps at 8.
  - When the counter wraps (8th bit):
    - `rx_data <=` post-shift value; pulse `rx_valid`.
    - If the byte count is 0, also assert `rx_pid` and compute `rx_pid_ok`.
    - Increment the byte count, using an 11-bit counter.
  - If the byte that would complete is number `MAX_BYTES+1`: do not emit it. Pulse `rx_error` and go to ABORT.
- **ABORT:**
  - Discard all bits.
  - Keep `rx_active` high.
  - Wait for `in_eop`.
- **EOP in DATA or ABORT:**
  - Pulse `rx_eop` and drop `rx_active`.
  - Return to IDLE and clear the shift register.
  - In DATA only, if the bit counter is non-zero (partial byte), also pulse `rx_error` in the same cycle as `rx_eop`.
  - In ABORT, no second `rx_error` pulse.
- **Simultaneous `in_eop` and `in_valid`:** `in_eop` wins and the bit is discarded.
- **EOP with zero bytes received (SYNC then EOP):** pulse `rx_eop` only; no error.
- **Reset mid-packet:** outputs clear immediately (asynchronous). No `rx_eop` is generated.

## Timing
- All outputs are registered.
- `rx_sop`, `rx_valid`, `rx_pid`, `rx_pid_ok` and `rx_error` (overflow) assert the cycle after the qualifying `in_valid` edge.
- `rx_eop` and alignment `rx_error` assert the cycle after `in_eop`.
- `rx_active` rises together with `rx_sop` and falls together with `rx_eop`.
- `rx_data` holds its value between strobes.
- Strobes are exactly one cycle wide, with no back-pressure.
- The bit rate must satisfy at most one `in_valid` per cycle.

## Structure
- **Package `usb_rx_pkg`:**
  - state enum `{RX_IDLE, RX_DATA, RX_ABORT}`
  - `USB_SYNC_PATTERN = 8'h80`
  - `function pid_check(logic [7:0])`
- **Sub-modules:** none. The shift register, counters and FSM live in one always_ff. The PID check is combinational from the package function.

## Test plan
- **Clean packet:**
  - Stimulus: SYNC bits 0000_0001, then PID `8'hA5` (LSB first), then byte `8'h3C`, then `in_eop`.
  - Response: `rx_sop`; `rx_valid`+`rx_pid` with `rx_data = A5` and `rx_pid_ok = 1`; `rx_valid` with `rx_data = 3C`; then `rx_eop` with no error and `rx_active` falling.
- **Bad PID:** PID `8'h55` → `rx_pid = 1`, `rx_pid_ok = 0`; the packet continues normally.
- **Misalignment:** SYNC, then PID `8'hD2`, then 5 bits, then `in_eop` → `rx_eop` and `rx_error` pulse in the same cycle.
- **Overflow:**
  - Setup: `MAX_BYTES = 3`.
  - Stimulus: SYNC, then 4 bytes, then `in_eop`.
  - Response: 3 `rx_valid` strobes; `rx_error` at the 4th byte boundary; `rx_active` stays high; `rx_eop` only at `in_eop`, with no second error.
- **Spaced strobes and noise:**
  - Stimulus: `in_valid` every 1–5 cycles with random gaps, and random noise containing no `8'h80` window before SYNC.
  - Response: no `rx_sop` until the SYNC pattern; bytes are assembled correctly afterwards.
- **Collision and reset:**
  - Stimulus: `in_eop` coincident with `in_valid` mid-byte, then `nRST` asserted mid-packet.
  - Response: the bit is dropped and `rx_eop`+`rx_error` pulse; on reset all outputs go to 0 asynchronously with no `rx_eop`.
